priority_encoder_rr: RTL and testbench

- Parametrised, registered successor to the team's 4-to-2 encoder.
- Encodes an N-bit request vector into a binary index.
- Supports two modes: fixed priority (highest index wins) and round-robin (rotating fairness).
- Output side uses a valid/ready handshake. Sits between request sources, such as interrupt lines or arbiter requesters, and a single consumer.

---
 rtl/enc_pkg.sv | 12 +
 rtl/rr_pick.sv | 49 ++++
 rtl/priority_encoder_rr.sv | 78 +++++++
 tb/tb_priority_encoder_rr.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority / round-robin encoder.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an n-entry request vector.
    function automatic int calc_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: highest index in fixed mode, or the first
// set bit at/after ptr (wrapping) in round-robin mode.
module rr_pick
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = calc_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [N-1:0]   mask_ge;
    logic [2*N-1:0] dbl;
    logic [W-1:0]   fixed_win;
    logic [W-1:0]   rr_win;

    // Upper half is the unmasked fallback, so the lowest set bit of the
    // double-width vector is the RR winner, offset by N when it wrapped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mask_ge = '0;
        for (int i = 0; i < N; i++) begin
            mask_ge[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask_ge};

        rr_win = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                rr_win = (i >= N) ? W'(i - N) : W'(i);
            end
        end

        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_win = W'(i);
            end
        end
    end

    assign any    = |req;
    assign winner = (mode == MODE_RR) ? rr_win : fixed_win;

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered N-bit request encoder with fixed/round-robin arbitration and a
// valid/ready output; the RR pointer is forwarded so back-to-back grants rotate.
module priority_encoder_rr
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = calc_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    logic [W-1:0] ptr;
    logic [W-1:0] next_ptr;
    logic         out_rr;
    logic         load;
    logic         handshake;
    logic [W-1:0] winner;
    logic         any;
    logic         multi;

    assign load      = !out_valid || out_ready;
    assign handshake = out_valid && out_ready;
    assign multi     = (req & (req - N'(1))) != '0;

    // Pointer advances only when an RR grant is consumed; the search below
    // sees the advanced value on the same edge.
    always_comb begin
        next_ptr = ptr;
        if (handshake && out_rr) begin
            next_ptr = (out_code == W'(N-1)) ? '0 : out_code + W'(1);
        end
    end

    rr_pick #(.N(N), .W(W)) u_pick (
        .req    (req),
        .ptr    (next_ptr),
        .mode   (mode),
        .winner (winner),
        .any    (any)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            out_rr     <= 1'b0;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
        end else begin
            ptr <= next_ptr;
            if (load) begin
                out_rr <= mode;
                if (any) begin
                    out_valid  <= 1'b1;
                    out_code   <= winner;
                    out_onehot <= N'(1) << winner;
                    out_multi  <= multi;
                end else begin
                    out_valid  <= 1'b0;
                    out_code   <= '0;
                    out_onehot <= '0;
                    out_multi  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed scoreboard bench for priority_encoder_rr (N=8).
module tb_priority_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] code;
        logic [N-1:0] onehot;
        logic         multi;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic [N-1:0] out_onehot;
    logic         out_multi;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb_q[$];

    // Reference model state
    exp_t         cur;
    logic         cur_rr;
    logic [W-1:0] mdl_ptr;

    priority_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur     = '0;
        cur_rr  = 1'b0;
        mdl_ptr = '0;
        sb_q.delete();
    endtask

    // Drive one cycle, push the model's expectation, clock, then compare.
    task automatic step(input logic [N-1:0] r, input logic m, input logic rdy, input string tag);
        logic         ld;
        logic [W-1:0] np;
        exp_t         e;
        int           w;
        req = r; mode = m; out_ready = rdy;
        ld = !cur.valid || rdy;
        np = mdl_ptr;
        if (cur.valid && rdy && cur_rr)
            np = (int'(cur.code) == N-1) ? '0 : cur.code + 3'd1;
        e = cur;
        if (ld) begin
            e = '0;
            if (r != '0) begin
                w = -1;
                if (m) begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && r[(int'(np) + k) % N]) w = (int'(np) + k) % N;
                end else begin
                    for (int k = N-1; k >= 0; k--)
                        if (w < 0 && r[k]) w = k;
                end
                e.valid  = 1'b1;
                e.code   = W'(w);
                e.onehot = N'(1) << w;
                e.multi  = $countones(r) > 1;
            end
            cur_rr = m;
        end
        cur     = e;
        mdl_ptr = np;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_valid"},  32'(out_valid),  32'(e.valid));
            check({tag, "_code"},   32'(out_code),   32'(e.code));
            check({tag, "_onehot"}, 32'(out_onehot), 32'(e.onehot));
            check({tag, "_multi"},  32'(out_multi),  32'(e.multi));
        end
    endtask

    initial begin
        logic [N-1:0] rnd;
        rst_n = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_code",   32'(out_code),   32'd0);
        check("rst_onehot", 32'(out_onehot), 32'd0);
        check("rst_multi",  32'(out_multi),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed priority
        step(8'b0010_1010, 1'b0, 1'b1, "fix_2a");
        check("fix_2a_code_abs",   32'(out_code),   32'd5);
        check("fix_2a_onehot_abs", 32'(out_onehot), 32'h20);
        check("fix_2a_multi_abs",  32'(out_multi),  32'd1);
        step(8'h04, 1'b0, 1'b1, "fix_04");
        check("fix_04_code_abs",  32'(out_code),  32'd2);
        check("fix_04_multi_abs", 32'(out_multi), 32'd0);

        // Empty
        step(8'h00, 1'b0, 1'b1, "empty0");
        check("empty0_valid_abs", 32'(out_valid), 32'd0);

        // Round-robin sweep, no bubbles
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b1, "rr_sweep");
            check("rr_sweep_code_abs",  32'(out_code),  32'(i % N));
            check("rr_sweep_valid_abs", 32'(out_valid), 32'd1);
        end

        // Wrap / skip
        step(8'h20, 1'b1, 1'b1, "rr_g5");
        check("rr_g5_code_abs", 32'(out_code), 32'd5);
        step(8'h03, 1'b1, 1'b1, "rr_wrap0");
        check("rr_wrap0_code_abs", 32'(out_code), 32'd0);
        step(8'h03, 1'b1, 1'b1, "rr_skip1");
        check("rr_skip1_code_abs", 32'(out_code), 32'd1);
        step(8'h03, 1'b1, 1'b1, "rr_wrap0b");
        check("rr_wrap0b_code_abs", 32'(out_code), 32'd0);

        // Empty cycles: ptr moves only on the accepted grant
        step(8'h00, 1'b1, 1'b1, "empty1");
        step(8'h00, 1'b1, 1'b1, "empty2");
        step(8'hFF, 1'b1, 1'b1, "rr_after_empty");
        check("rr_after_empty_code_abs", 32'(out_code), 32'd1);

        // Backpressure
        step(8'h08, 1'b0, 1'b1, "bp_load");
        check("bp_load_code_abs", 32'(out_code), 32'd3);
        for (int i = 0; i < 4; i++) begin
            rnd = N'($urandom);
            step(rnd, 1'($urandom), 1'b0, "bp_hold");
            check("bp_hold_code_abs", 32'(out_code), 32'd3);
        end
        rnd = N'($urandom) | 8'h01;
        step(rnd, 1'b0, 1'b1, "bp_release");

        // Asynchronous reset mid-stall
        step(8'h10, 1'b0, 1'b1, "pre_rst");
        step(8'hC0, 1'b0, 1'b0, "stall_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_valid",  32'(out_valid),  32'd0);
        check("midrst_code",   32'(out_code),   32'd0);
        check("midrst_onehot", 32'(out_onehot), 32'd0);
        check("midrst_multi",  32'(out_multi),  32'd0);
        #2 rst_n = 1'b1;
        step(8'h00, 1'b0, 1'b1, "post_rst");
        step(8'hFF, 1'b1, 1'b1, "post_rst_rr");
        check("post_rst_rr_code_abs", 32'(out_code), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
